// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, ALU control encodings and issue FSM states
// Shared by alu_op_decode and alu_issue_ctrl. No ports.
package alu_pkg;

    // Request opcodes (4'hC..4'hF are illegal)
    localparam logic [3:0] OP_AND  = 4'h0;
    localparam logic [3:0] OP_OR   = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_NOR  = 4'h4;
    localparam logic [3:0] OP_NAND = 4'h5;
    localparam logic [3:0] OP_SLT  = 4'h6;
    localparam logic [3:0] OP_SGT  = 4'h7;
    localparam logic [3:0] OP_SLE  = 4'h8;
    localparam logic [3:0] OP_SGE  = 4'h9;
    localparam logic [3:0] OP_SEQ  = 4'hA;
    localparam logic [3:0] OP_SNE  = 4'hB;

    // ALU_control = {A_inv, B_inv, op[1:0]}
    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;
    localparam logic [3:0] CTRL_NAND = 4'b1101;
    localparam logic [3:0] CTRL_CMP  = 4'b0111;

    // bonus_control selects the compare condition when ALU_control is CTRL_CMP
    localparam logic [2:0] BONUS_NONE = 3'b000;
    localparam logic [2:0] BONUS_SLT  = 3'b000;
    localparam logic [2:0] BONUS_SGT  = 3'b001;
    localparam logic [2:0] BONUS_SLE  = 3'b010;
    localparam logic [2:0] BONUS_SGE  = 3'b011;
    localparam logic [2:0] BONUS_SEQ  = 3'b110;
    localparam logic [2:0] BONUS_SNE  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } issue_state_t;

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational request opcode to ALU control decode
// Ports:
//   op        in  4  request opcode
//   ctrl      out 4  ALU_control {A_inv,B_inv,op[1:0]}
//   bonus     out 3  bonus_control
//   is_arith  out 1  ADD/SUB: cout/overflow are meaningful
//   illegal   out 1  opcode outside the table
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [3:0] op,
    output logic [3:0] ctrl,
    output logic [2:0] bonus,
    output logic       is_arith,
    output logic       illegal
);

    always_comb begin
        ctrl     = CTRL_AND;
        bonus    = BONUS_NONE;
        is_arith = 1'b0;
        illegal  = 1'b0;
        case (op)
            OP_AND:  ctrl = CTRL_AND;
            OP_OR:   ctrl = CTRL_OR;
            OP_ADD:  begin ctrl = CTRL_ADD; is_arith = 1'b1; end
            OP_SUB:  begin ctrl = CTRL_SUB; is_arith = 1'b1; end
            OP_NOR:  ctrl = CTRL_NOR;
            OP_NAND: ctrl = CTRL_NAND;
            OP_SLT:  begin ctrl = CTRL_CMP; bonus = BONUS_SLT; end
            OP_SGT:  begin ctrl = CTRL_CMP; bonus = BONUS_SGT; end
            OP_SLE:  begin ctrl = CTRL_CMP; bonus = BONUS_SLE; end
            OP_SGE:  begin ctrl = CTRL_CMP; bonus = BONUS_SGE; end
            OP_SEQ:  begin ctrl = CTRL_CMP; bonus = BONUS_SEQ; end
            OP_SNE:  begin ctrl = CTRL_CMP; bonus = BONUS_SNE; end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - request/response issue controller for an external 32-bit ALU
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req_valid/req_ready             request handshake; req_op, req_a, req_b payload
//   rsp_valid/rsp_ready             response handshake; rsp_result, rsp_zero, rsp_cout,
//                                   rsp_ovf, rsp_err payload
//   alu_rst_n                       ALU reset, released only while executing a legal op
//   alu_src1/alu_src2/alu_ctrl/alu_bonus   registered ALU inputs
//   alu_result/alu_zero/alu_cout/alu_overflow  ALU outputs
//   clr_sticky/sticky_ovf           sticky overflow clear / status
//   op_count                        accepted-request counter (wraps)
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_cout,
    output logic             rsp_ovf,
    output logic             rsp_err,
    output logic             alu_rst_n,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    output logic [3:0]       alu_ctrl,
    output logic [2:0]       alu_bonus,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    input  logic             alu_cout,
    input  logic             alu_overflow,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic [CNT_W-1:0] op_count
);

    issue_state_t state, state_nxt;

    logic [3:0] dec_ctrl;
    logic [2:0] dec_bonus;
    logic       dec_arith;
    logic       dec_illegal;

    // Properties of the op currently held in the alu_* registers
    logic       arith_q;
    logic       illegal_q;

    logic       accept;
    logic       capture;
    logic       ovf_event;

    alu_op_decode u_decode (
        .op       (req_op),
        .ctrl     (dec_ctrl),
        .bonus    (dec_bonus),
        .is_arith (dec_arith),
        .illegal  (dec_illegal)
    );

    assign accept    = (state == ST_IDLE) && req_valid;
    assign capture   = (state == ST_EXEC);
    assign ovf_event = capture && !illegal_q && arith_q && alu_overflow;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (req_valid) state_nxt = ST_EXEC;
            ST_EXEC: state_nxt = ST_RESP;
            ST_RESP: if (rsp_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_rst_n = 1'b0;
        case (state)
            ST_IDLE: req_ready = 1'b1;
            ST_EXEC: alu_rst_n = !illegal_q;
            ST_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // ALU input registers: loaded on accept, held otherwise. Illegal ops park
    // them at zero so the ALU never sees stray operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_src1  <= '0;
            alu_src2  <= '0;
            alu_ctrl  <= '0;
            alu_bonus <= '0;
            arith_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (accept) begin
            arith_q   <= dec_arith;
            illegal_q <= dec_illegal;
            if (dec_illegal) begin
                alu_src1  <= '0;
                alu_src2  <= '0;
                alu_ctrl  <= '0;
                alu_bonus <= '0;
            end else begin
                alu_src1  <= req_a;
                alu_src2  <= req_b;
                alu_ctrl  <= dec_ctrl;
                alu_bonus <= dec_bonus;
            end
        end
    end

    // Response capture at the end of EXEC; stable through RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_cout   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
        end else if (capture) begin
            if (illegal_q) begin
                rsp_result <= '0;
                rsp_zero   <= 1'b1;
                rsp_cout   <= 1'b0;
                rsp_ovf    <= 1'b0;
                rsp_err    <= 1'b1;
            end else begin
                rsp_result <= alu_result;
                rsp_zero   <= alu_zero;
                rsp_cout   <= alu_cout && arith_q;
                rsp_ovf    <= alu_overflow && arith_q;
                rsp_err    <= 1'b0;
            end
        end
    end

    // Sticky overflow: a new overflow beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
        end else if (ovf_event) begin
            sticky_ovf <= 1'b1;
        end else if (clr_sticky) begin
            sticky_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (accept) begin
            op_count <= op_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - scoreboard bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_cout, rsp_ovf, rsp_err;
    logic        alu_rst_n;
    logic [31:0] alu_src1, alu_src2;
    logic [3:0]  alu_ctrl;
    logic [2:0]  alu_bonus;
    logic [31:0] alu_result;
    logic        alu_zero, alu_cout, alu_overflow;
    logic        clr_sticky = 1'b0;
    logic        sticky_ovf;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .alu_rst_n(alu_rst_n), .alu_src1(alu_src1), .alu_src2(alu_src2),
        .alu_ctrl(alu_ctrl), .alu_bonus(alu_bonus),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_cout(alu_cout),
        .alu_overflow(alu_overflow),
        .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .op_count(op_count)
    );

    // Behavioural stand-in for the parent's ALU. Adder flags are produced for
    // every op so that masking in the controller is actually exercised.
    logic [31:0] m_a, m_b, m_r;
    logic [32:0] m_sum;
    logic        m_lt, m_eq;
    always_comb begin
        m_a = alu_ctrl[3] ? ~alu_src1 : alu_src1;
        m_b = alu_ctrl[2] ? ~alu_src2 : alu_src2;
        m_sum = {1'b0, m_a} + {1'b0, m_b} + {32'd0, alu_ctrl[2]};
        m_lt = $signed(alu_src1) < $signed(alu_src2);
        m_eq = (alu_src1 == alu_src2);
        m_r = '0;
        case (alu_ctrl[1:0])
            2'b00: m_r = m_a & m_b;
            2'b01: m_r = m_a | m_b;
            2'b10: m_r = m_sum[31:0];
            default: begin
                case (alu_bonus)
                    3'b000: m_r = {31'd0, m_lt};
                    3'b001: m_r = {31'd0, !m_lt && !m_eq};
                    3'b010: m_r = {31'd0, m_lt || m_eq};
                    3'b011: m_r = {31'd0, !m_lt};
                    3'b110: m_r = {31'd0, m_eq};
                    3'b100: m_r = {31'd0, !m_eq};
                    default: m_r = '0;
                endcase
            end
        endcase
        alu_result   = '0;
        alu_zero     = 1'b0;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        if (alu_rst_n) begin
            alu_result   = m_r;
            alu_zero     = (m_r == 32'd0);
            alu_cout     = m_sum[32];
            alu_overflow = (m_a[31] == m_b[31]) && (m_sum[31] != m_a[31]);
        end
    end

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, res;
        logic        z, c, o, e;
        logic [3:0]  ctrl;
        logic [2:0]  bonus;
    } vec_t;

    vec_t vecs[14];
    vec_t exp_q[$];

    int n_cmp = 0;
    int n_miss = 0;
    int n_issued = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare on each response handshake
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                vec_t ev;
                ev = exp_q.pop_front();
                chk("rsp_result", rsp_result, ev.res);
                chk("rsp_zero", 32'(rsp_zero), 32'(ev.z));
                chk("rsp_cout", 32'(rsp_cout), 32'(ev.c));
                chk("rsp_ovf", 32'(rsp_ovf), 32'(ev.o));
                chk("rsp_err", 32'(rsp_err), 32'(ev.e));
                chk("alu_ctrl", 32'(alu_ctrl), 32'(ev.ctrl));
                chk("alu_bonus", 32'(alu_bonus), 32'(ev.bonus));
                chk("alu_src1", alu_src1, ev.e ? 32'd0 : ev.a);
            end
        end
    end

    // Called just after a rising edge with the DUT idle; returns at the
    // falling edge of the first RESP cycle (two edges after the drive edge).
    task automatic issue(input vec_t v);
        req_op = v.op;
        req_a = v.a;
        req_b = v.b;
        req_valid = 1'b1;
        exp_q.push_back(v);
        n_issued++;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("lat_exec_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("alu_rst_n_exec", 32'(alu_rst_n), 32'(!v.e));
        @(negedge clk);
        chk("lat_resp_rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (req_ready) break;
        end
        if (k == 20) begin
            n_cmp++;
            n_miss++;
            $display("FAIL idle_timeout: req_ready stuck at 0 expected 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          op     a             b             res           z     c     o     e     ctrl     bonus
        vecs[0]  = '{4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 3'b000};
        vecs[1]  = '{4'h3, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 4'b0110, 3'b000};
        vecs[2]  = '{4'h0, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 3'b000};
        vecs[3]  = '{4'h6, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 3'b000};
        vecs[4]  = '{4'h9, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111, 3'b011};
        vecs[5]  = '{4'hA, 32'h00000007, 32'h00000007, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 3'b110};
        vecs[6]  = '{4'hB, 32'h00000007, 32'h00000007, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0111, 3'b100};
        vecs[7]  = '{4'hD, 32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 3'b000};
        vecs[8]  = '{4'h1, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 3'b000};
        vecs[9]  = '{4'h4, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1100, 3'b000};
        vecs[10] = '{4'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1101, 3'b000};
        vecs[11] = '{4'h7, 32'h00000003, 32'h00000002, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 3'b001};
        vecs[12] = '{4'h8, 32'h00000002, 32'h00000002, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 3'b010};
        vecs[13] = '{4'h3, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0110, 3'b000};

        // Reset values
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_rst_n", 32'(alu_rst_n), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_sticky", 32'(sticky_ovf), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD overflow sets sticky
        issue(vecs[0]);
        wait_idle();
        chk("sticky_after_add_ovf", 32'(sticky_ovf), 32'd1);
        clr_sticky = 1'b1;
        @(posedge clk);
        #1 clr_sticky = 1'b0;
        chk("sticky_cleared", 32'(sticky_ovf), 32'd0);

        // Remaining ops; none may set sticky (masked or no overflow)
        for (int i = 1; i <= 12; i++) begin
            issue(vecs[i]);
            wait_idle();
        end
        chk("sticky_masked", 32'(sticky_ovf), 32'd0);
        chk("op_count_13", 32'(op_count), 32'd13);

        // Overflow capture while clear is held: set wins
        clr_sticky = 1'b1;
        issue(vecs[13]);
        chk("sticky_set_wins", 32'(sticky_ovf), 32'd1);
        clr_sticky = 1'b0;
        wait_idle();

        // Backpressure: 5 stalled RESP cycles, then a one-cycle handshake
        rsp_ready = 1'b0;
        issue(vecs[8]);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_rsp_result", rsp_result, 32'h000000FF);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("handshake_req_ready", 32'(req_ready), 32'd1);
        chk("handshake_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("op_count_15", 32'(op_count), 32'd15);
        chk("sticky_before_rst", 32'(sticky_ovf), 32'd1);

        // Reset during EXEC discards the in-flight op
        req_op = 4'h2;
        req_a = 32'h7FFFFFFF;
        req_b = 32'h00000001;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_alu_rst_n", 32'(alu_rst_n), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_req_ready", 32'(req_ready), 32'd1);
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_alu_rst_n", 32'(alu_rst_n), 32'd0);
        chk("midrst_sticky", 32'(sticky_ovf), 32'd0);
        chk("midrst_op_count", 32'(op_count), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        // Recovery after reset
        issue(vecs[5]);
        wait_idle();
        chk("op_count_after_rst", 32'(op_count), 32'd1);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_miss);
        $finish;
    end

endmodule
